// File: rtl/fuse_matrix_pkg.sv
// -----------------------------------------------------------------------------
// fuse_matrix_pkg
// Shared types and constants for the fuse matrix controller.
//   game_state_e : game FSM states (IDLE, BURN, DEFUSED, EXPLODED)
//   COLS         : matrix column count (fixed at 8)
//   *_PAT        : column bitmaps for the bomb picture
//   col_drive_t  : one row's red/green column drive pair
// -----------------------------------------------------------------------------
package fuse_matrix_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BURN     = 2'd1,
    DEFUSED  = 2'd2,
    EXPLODED = 2'd3
  } game_state_e;

  localparam int COLS = 8;

  localparam logic [COLS-1:0] FUSE_PAT      = 8'b0001_1000;
  localparam logic [COLS-1:0] BODY_EDGE_PAT = 8'b0001_1000;
  localparam logic [COLS-1:0] BODY_MID_PAT  = 8'b0010_0100;
  localparam logic [COLS-1:0] EXPLODE_PAT   = 8'hFF;

  typedef struct packed {
    logic [COLS-1:0] red;
    logic [COLS-1:0] gre;
  } col_drive_t;

endpackage

// File: rtl/fuse_matrix_ctrl_if.sv
// -----------------------------------------------------------------------------
// fuse_matrix_ctrl_if
// Bundles the game-control inputs and the matrix/status outputs.
//   enable, start, defuse : from game-control logic
//   hang                  : row select, active-low, row 0 = MSB
//   red, gre              : column drives, active-high
//   fail, defused         : sticky game result flags
//   fuse_left             : unburnt fuse rows
// Modports: master = game control / pin side, slave = controller.
// -----------------------------------------------------------------------------
interface fuse_matrix_ctrl_if #(
  parameter int ROWS     = 8,
  parameter int FUSE_LEN = 4
);
  import fuse_matrix_pkg::*;

  logic                               enable;
  logic                               start;
  logic                               defuse;
  logic [ROWS-1:0]                    hang;
  logic [COLS-1:0]                    red;
  logic [COLS-1:0]                    gre;
  logic                               fail;
  logic                               defused;
  logic [$clog2(FUSE_LEN+1)-1:0]      fuse_left;

  modport master (
    output enable, start, defuse,
    input  hang, red, gre, fail, defused, fuse_left
  );

  modport slave (
    input  enable, start, defuse,
    output hang, red, gre, fail, defused, fuse_left
  );

endinterface

// File: rtl/fuse_matrix_scan.sv
// -----------------------------------------------------------------------------
// fuse_matrix_scan
// Row-scan divider and row index for the matrix.
//   clk, rst (async, active-low), enable (0 freezes the scan)
//   row_idx : current row r, 0..ROWS-1, advancing every SCAN_DIV enabled clks
//   row_sel : active-low one-hot row select for row_idx (row 0 = MSB)
// -----------------------------------------------------------------------------
module fuse_matrix_scan #(
  parameter int ROWS     = 8,
  parameter int SCAN_DIV = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  output logic [$clog2(ROWS)-1:0]  row_idx,
  output logic [ROWS-1:0]          row_sel
);

  localparam int RW = $clog2(ROWS);
  // A 1-bit counter is kept even for SCAN_DIV=1; it simply stays at zero.
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [SW-1:0] scan_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      row_idx  <= '0;
    end else if (enable) begin
      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        row_idx  <= (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + RW'(1);
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
    end
  end

  // Row 0 drives the MSB of the select vector.
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      row_sel[i] = (i != (ROWS - 1 - int'(row_idx)));
    end
  end

endmodule

// File: rtl/fuse_matrix_ctrl.sv
// -----------------------------------------------------------------------------
// fuse_matrix_ctrl
// Row-scanned bicolour LED matrix driver showing a bomb whose fuse burns down
// one row per tick, with pause, defuse and fuse-remaining count.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : fuse_matrix_ctrl_if.slave (enable/start/defuse in; hang/red/gre,
//          fail/defused, fuse_left out)
// Optional build macro FUSE_BLINK_EN: the lowest lit fuse row drops its green
// drive during the second half of each tick period (ember flicker).
// -----------------------------------------------------------------------------
module fuse_matrix_ctrl
  import fuse_matrix_pkg::*;
#(
  parameter int ROWS     = 8,
  parameter int FUSE_LEN = 4,
  parameter int SCAN_DIV = 1,
  parameter int TICK_DIV = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  fuse_matrix_ctrl_if.slave    bus
);

  localparam int RW = $clog2(ROWS);
  localparam int FW = $clog2(FUSE_LEN + 1);
  localparam int TW = $clog2(TICK_DIV);

  game_state_e     state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [FW-1:0]   left_q, left_d;

  logic [RW-1:0]   row_idx;
  logic [ROWS-1:0] row_sel;

  logic [ROWS-1:0] hang_q;
  logic [COLS-1:0] red_q, gre_q;

  fuse_matrix_scan #(
    .ROWS     (ROWS),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .enable  (bus.enable),
    .row_idx (row_idx),
    .row_sel (row_sel)
  );

  // ---------------------------------------------------------------------------
  // Game FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      left_q  <= FW'(FUSE_LEN);
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      left_q  <= left_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Game FSM: next state. enable=0 freezes everything. Defuse is checked ahead
  // of the tick so it wins over a coincident final tick and fuse_left stays 1.
  // fuse_left cannot underflow: reaching zero leaves BURN on the same edge.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    left_d  = left_q;
    if (bus.enable) begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d = BURN;
            tick_d  = '0;
          end
        end
        BURN: begin
          if (bus.defuse) begin
            state_d = DEFUSED;
          end else if (bus.start) begin
            if (tick_q == TW'(TICK_DIV - 1)) begin
              tick_d = '0;
              left_d = left_q - FW'(1);
              if (left_q == FW'(1)) state_d = EXPLODED;
            end else begin
              tick_d = tick_q + TW'(1);
            end
          end
        end
        DEFUSED, EXPLODED: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Column mux for the row currently being scanned.
  // ---------------------------------------------------------------------------
  int              row_i;
  int              first_lit;
  logic            is_fuse;
  logic            lit;
  logic [COLS-1:0] pat;
  col_drive_t      cols;

  always_comb begin
    row_i     = int'(row_idx);
    first_lit = FUSE_LEN - int'(left_q);
    is_fuse   = (row_i < FUSE_LEN);
    lit       = is_fuse && (row_i >= first_lit);
    if (is_fuse)                                      pat = FUSE_PAT;
    else if (row_i == FUSE_LEN || row_i == ROWS - 1)  pat = BODY_EDGE_PAT;
    else                                              pat = BODY_MID_PAT;

    cols = '0;
    unique case (state_q)
      IDLE, BURN: begin
        if (!is_fuse) begin
          cols.red = pat;
        end else if (lit) begin
          cols.red = pat;
          cols.gre = pat;
`ifdef FUSE_BLINK_EN
          if (row_i == first_lit && int'(tick_q) >= TICK_DIV / 2) cols.gre = '0;
`endif
        end
      end
      DEFUSED: begin
        if (!is_fuse) cols.gre = pat;
      end
      EXPLODED: begin
        cols.red = EXPLODE_PAT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered matrix drive: one clk behind the scan index; blanked while
  // disabled.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hang_q <= '1;
      red_q  <= '0;
      gre_q  <= '0;
    end else if (!bus.enable) begin
      hang_q <= '1;
      red_q  <= '0;
      gre_q  <= '0;
    end else begin
      hang_q <= row_sel;
      red_q  <= cols.red;
      gre_q  <= cols.gre;
    end
  end

  assign bus.hang      = hang_q;
  assign bus.red       = red_q;
  assign bus.gre       = gre_q;
  assign bus.fail      = (state_q == EXPLODED);
  assign bus.defused   = (state_q == DEFUSED);
  assign bus.fuse_left = left_q;

endmodule

// File: tb/tb_fuse_matrix_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fuse_matrix_ctrl
// Self-checking bench for fuse_matrix_ctrl (ROWS=8, FUSE_LEN=4, SCAN_DIV=1,
// TICK_DIV=20). Stimulus pushes hand-computed expectations into a queue; a
// monitor process pops and compares them against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_fuse_matrix_ctrl;

  localparam int ROWS     = 8;
  localparam int FUSE_LEN = 4;
  localparam int SCAN_DIV = 1;
  localparam int TICK_DIV = 20;

  typedef enum int {S_HANG, S_RED, S_GRE, S_FAIL, S_DEF, S_LEFT} sig_e;

  typedef struct {
    string       name;
    sig_e        sig;
    logic [15:0] exp;
  } exp_t;

  // Per-row column images, row 0 first.
  localparam logic [0:7][7:0] RED_IDLE = {8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h24, 8'h24, 8'h18};
  localparam logic [0:7][7:0] GRE_IDLE = {8'h18, 8'h18, 8'h18, 8'h18, 8'h00, 8'h00, 8'h00, 8'h00};
  localparam logic [0:7][7:0] RED_B3   = {8'h00, 8'h18, 8'h18, 8'h18, 8'h18, 8'h24, 8'h24, 8'h18};
  localparam logic [0:7][7:0] GRE_B3   = {8'h00, 8'h18, 8'h18, 8'h18, 8'h00, 8'h00, 8'h00, 8'h00};
`ifdef FUSE_BLINK_EN
  localparam logic [0:7][7:0] GRE_B3_LATE = {8'h00, 8'h00, 8'h18, 8'h18, 8'h00, 8'h00, 8'h00, 8'h00};
`else
  localparam logic [0:7][7:0] GRE_B3_LATE = {8'h00, 8'h18, 8'h18, 8'h18, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
  localparam logic [0:7][7:0] RED_DEF  = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  localparam logic [0:7][7:0] GRE_DEF  = {8'h00, 8'h00, 8'h00, 8'h00, 8'h18, 8'h24, 8'h24, 8'h18};

  logic clk = 1'b0;
  logic rst = 1'b1;

  fuse_matrix_ctrl_if #(.ROWS(ROWS), .FUSE_LEN(FUSE_LEN)) bus ();

  fuse_matrix_ctrl #(
    .ROWS     (ROWS),
    .FUSE_LEN (FUSE_LEN),
    .SCAN_DIV (SCAN_DIV),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  event exp_ev;
  int   n_pass  = 0;
  int   n_total = 0;
  int   r_model = 0;   // scan index the DUT will display on the next enabled edge
  int   shown   = 0;   // row displayed after the most recent enabled edge

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] dut_value(input sig_e s);
    case (s)
      S_HANG:  return {8'h00, bus.hang};
      S_RED:   return {8'h00, bus.red};
      S_GRE:   return {8'h00, bus.gre};
      S_FAIL:  return {15'h0, bus.fail};
      S_DEF:   return {15'h0, bus.defused};
      default: return {13'h0, bus.fuse_left};
    endcase
  endfunction

  // Monitor: drains every expectation pushed in the current time step.
  initial begin
    exp_t e;
    forever begin
      @(exp_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, dut_value(e.sig), e.exp);
      end
    end
  end

  task automatic expect_sig(input string name, input sig_e s, input logic [15:0] v);
    exp_t e;
    e.name = name;
    e.sig  = s;
    e.exp  = v;
    exp_q.push_back(e);
    -> exp_ev;
  endtask

  function automatic logic [15:0] row_hang(input int r);
    logic [7:0] h;
    h = ~(8'h80 >> r);
    return {8'h00, h};
  endfunction

  // One clk: inputs were driven at the previous negedge, results read at the next.
  task automatic step();
    @(posedge clk);
    if (bus.enable && rst) begin
      shown   = r_model;
      r_model = (r_model + 1) % ROWS;
    end
    @(negedge clk);
  endtask

  task automatic step_n(input int n);
    repeat (n) step();
  endtask

  task automatic sweep(input string tag, input logic [0:7][7:0] rt, input logic [0:7][7:0] gt);
    repeat (ROWS) begin
      step();
      expect_sig($sformatf("%s r%0d hang", tag, shown), S_HANG, row_hang(shown));
      expect_sig($sformatf("%s r%0d red", tag, shown), S_RED, {8'h00, rt[shown]});
      expect_sig($sformatf("%s r%0d gre", tag, shown), S_GRE, {8'h00, gt[shown]});
    end
  endtask

  // Asserts reset between edges, checks outputs before the next edge, releases.
  task automatic reset_dut(input string tag);
    @(negedge clk);
    rst        = 1'b0;
    bus.enable = 1'b1;
    bus.start  = 1'b0;
    bus.defuse = 1'b0;
    #1;
    expect_sig({tag, " hang"},    S_HANG, 16'h00FF);
    expect_sig({tag, " red"},     S_RED,  16'h0000);
    expect_sig({tag, " gre"},     S_GRE,  16'h0000);
    expect_sig({tag, " fail"},    S_FAIL, 16'h0000);
    expect_sig({tag, " defused"}, S_DEF,  16'h0000);
    expect_sig({tag, " left"},    S_LEFT, 16'd4);
    @(negedge clk);
    rst     = 1'b1;
    r_model = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.enable = 1'b0;
    bus.start  = 1'b0;
    bus.defuse = 1'b0;

    // ---- Game 1: idle scan, then full burn to explosion ----
    reset_dut("reset");
    sweep("idle", RED_IDLE, GRE_IDLE);
    step();
    expect_sig("idle wrap hang", S_HANG, 16'h007F);
    expect_sig("idle fail", S_FAIL, 16'h0000);
    expect_sig("idle left", S_LEFT, 16'd4);

    bus.start = 1'b1;
    step();                                   // BURN entry edge, k=0
    expect_sig("burn k0 left", S_LEFT, 16'd4);
    step_n(19);                               // k=19
    expect_sig("burn k19 left", S_LEFT, 16'd4);
    step();                                   // k=20
    expect_sig("burn k20 left", S_LEFT, 16'd3);
    sweep("burn3 early", RED_B3, GRE_B3);     // k=21..28, tick 0..7
    step_n(2);                                // k=30
    sweep("burn3 late", RED_B3, GRE_B3_LATE); // k=31..38, tick 10..17
    step_n(2);                                // k=40
    expect_sig("burn k40 left", S_LEFT, 16'd2);
    step_n(20);                               // k=60
    expect_sig("burn k60 left", S_LEFT, 16'd1);
    step_n(19);                               // k=79
    expect_sig("burn k79 fail", S_FAIL, 16'h0000);
    expect_sig("burn k79 left", S_LEFT, 16'd1);
    step();                                   // k=80
    expect_sig("explode fail", S_FAIL, 16'h0001);
    expect_sig("explode left", S_LEFT, 16'd0);
    expect_sig("explode defused", S_DEF, 16'h0000);
    repeat (2) begin
      step();
      expect_sig("explode red", S_RED, 16'h00FF);
      expect_sig("explode gre", S_GRE, 16'h0000);
      expect_sig("explode hang", S_HANG, row_hang(shown));
    end

    // ---- Game 2: pause, resume, defuse at fuse_left=2 ----
    reset_dut("reset after explode");
    step_n(2);
    bus.start = 1'b1;
    step();                                   // k=0
    step_n(25);                               // k=25, tick=5
    expect_sig("pre-pause left", S_LEFT, 16'd3);
    bus.start = 1'b0;
    step_n(50);
    expect_sig("paused left", S_LEFT, 16'd3);
    bus.start = 1'b1;
    step_n(14);                               // tick back to 19
    expect_sig("resume left hold", S_LEFT, 16'd3);
    step();                                   // wrap
    expect_sig("resume left dec", S_LEFT, 16'd2);
    bus.defuse = 1'b1;
    step();
    expect_sig("defuse flag", S_DEF, 16'h0001);
    expect_sig("defuse fail", S_FAIL, 16'h0000);
    expect_sig("defuse left", S_LEFT, 16'd2);
    bus.defuse = 1'b0;
    sweep("defused", RED_DEF, GRE_DEF);
    bus.start = 1'b0;
    step_n(5);
    bus.start  = 1'b1;
    bus.defuse = 1'b1;
    step_n(60);
    bus.defuse = 1'b0;
    expect_sig("defused hold left", S_LEFT, 16'd2);
    expect_sig("defused hold fail", S_FAIL, 16'h0000);
    expect_sig("defused hold flag", S_DEF, 16'h0001);

    // ---- Game 3: defuse coincident with the final tick ----
    reset_dut("reset after defuse");
    bus.start = 1'b1;
    step();                                   // k=0
    step_n(79);                               // k=79, tick=19, left=1
    expect_sig("race pre left", S_LEFT, 16'd1);
    bus.defuse = 1'b1;
    step();
    expect_sig("race defused", S_DEF, 16'h0001);
    expect_sig("race fail", S_FAIL, 16'h0000);
    expect_sig("race left", S_LEFT, 16'd1);
    bus.defuse = 1'b0;
    step_n(25);
    expect_sig("race later fail", S_FAIL, 16'h0000);
    expect_sig("race later left", S_LEFT, 16'd1);

    // ---- Game 4: enable=0 mid-burn, then async reset mid-burn ----
    reset_dut("reset after race");
    bus.start = 1'b1;
    step();                                   // k=0
    step_n(30);                               // k=30, tick=10, left=3
    bus.enable = 1'b0;
    step();
    expect_sig("disable hang", S_HANG, 16'h00FF);
    expect_sig("disable red", S_RED, 16'h0000);
    expect_sig("disable gre", S_GRE, 16'h0000);
    step_n(30);
    expect_sig("disable left", S_LEFT, 16'd3);
    expect_sig("disable fail", S_FAIL, 16'h0000);
    bus.enable = 1'b1;
    step();                                   // k=31
    expect_sig("re-enable hang", S_HANG, row_hang(shown));
    step_n(8);                                // k=39
    expect_sig("re-enable left hold", S_LEFT, 16'd3);
    step();                                   // k=40
    expect_sig("re-enable left dec", S_LEFT, 16'd2);
    reset_dut("async reset mid-burn");

    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
